// File: rtl/wb_initiator_seq.sv
// ----------------------------------------------------------------------------
// wb_initiator_seq
//
// Wishbone classic single-transfer initiator. It accepts one command on a
// valid/ready port, runs it as a single classic cycle on the WB bus, and
// returns read data (or an error) on a valid/ready response port. Only one
// transfer is outstanding at a time. The next command is accepted no earlier
// than one cycle after the response handshake.
//
// Parameters
//   TIMEOUT_CYCLES : BUS cycles without ack before abort (>=2). Used only when
//                    the timeout option is enabled.
//   CNT_W          : width of the transaction and error status counters.
//
// Optional feature
//   `define WB_INITIATOR_TIMEOUT_EN : abort a transfer that is not acked within
//                                     TIMEOUT_CYCLES. The abort returns
//                                     rsp_err_o=1 and increments err_cnt_o.
//                                     If the macro is not defined, BUS waits
//                                     for ack forever, and rsp_err_o and
//                                     err_cnt_o are tied to 0.
//
// Ports
//   wb_clk_i, wb_rst_i           : clock and synchronous active-high reset
//   cmd_valid_i / cmd_ready_o    : command handshake
//   cmd_we_i, cmd_adr_i,
//   cmd_dat_i, cmd_sel_i         : command contents (write flag, byte address,
//                                  write data, byte selects)
//   rsp_valid_o / rsp_ready_i    : response handshake. The response is held
//                                  until it is consumed.
//   rsp_dat_o, rsp_err_o         : read data (0 for writes and errors) and the
//                                  timeout flag
//   wbm_*                        : Wishbone classic initiator bus
//   txn_cnt_o, err_cnt_o         : counts of acked and timed-out transfers.
//                                  Both wrap.
// ----------------------------------------------------------------------------
module wb_initiator_seq #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 16
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic             cmd_we_i,
   input  logic [31:0]      cmd_adr_i,
   input  logic [31:0]      cmd_dat_i,
   input  logic [3:0]       cmd_sel_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [31:0]      rsp_dat_o,
   output logic             rsp_err_o,
   output logic             wbm_cyc_o,
   output logic             wbm_stb_o,
   output logic             wbm_we_o,
   output logic [3:0]       wbm_sel_o,
   output logic [31:0]      wbm_adr_o,
   output logic [31:0]      wbm_dat_o,
   input  logic [31:0]      wbm_dat_i,
   input  logic             wbm_ack_i,
   output logic [CNT_W-1:0] txn_cnt_o,
   output logic [CNT_W-1:0] err_cnt_o
);

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("wb_initiator_seq: TIMEOUT_CYCLES must be >= 2");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic             timeout_hit;   // BUS cycle ends by abort rather than ack
   logic             wbm_we_q;
   logic [3:0]       wbm_sel_q;
   logic [31:0]      wbm_adr_q;
   logic [31:0]      wbm_dat_q;
   logic             rsp_valid_q;
   logic [31:0]      rsp_dat_q;
   logic [CNT_W-1:0] txn_cnt_q;

   // -------------------------------------------------------------------------
   // Timeout option
   // -------------------------------------------------------------------------
`ifdef WB_INITIATOR_TIMEOUT_EN
   localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES);

   logic [WAIT_W-1:0] wait_cnt;
   logic              rsp_err_q;
   logic [CNT_W-1:0]  err_cnt_q;

   // An ack on the final wait edge takes priority over the abort.
   assign timeout_hit = (state == BUS) && !wbm_ack_i &&
                        (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wait_cnt  <= '0;
         rsp_err_q <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         // The counter is restarted when a command enters BUS. It then counts
         // each BUS cycle in which no ack arrives.
         if (state == IDLE && cmd_valid_i) begin
            wait_cnt <= '0;
         end else if (state == BUS && !wbm_ack_i) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
         end

         if (timeout_hit) begin
            rsp_err_q <= 1'b1;
            err_cnt_q <= err_cnt_q + CNT_W'(1);
         end else if (state == RESP && rsp_ready_i) begin
            rsp_err_q <= 1'b0;
         end
      end
   end

   assign rsp_err_o = rsp_err_q;
   assign err_cnt_o = err_cnt_q;
`else
   assign timeout_hit = 1'b0;
   assign rsp_err_o   = 1'b0;
   assign err_cnt_o   = '0;
`endif

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   // NOTE: clocked state uses non-blocking assignments, so every flop samples
   // the values from before the edge, whatever order the processes run in.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) state <= IDLE;
      else          state <= state_nxt;
   end

   // -------------------------------------------------------------------------
   // FSM: next-state logic
   // -------------------------------------------------------------------------
   // NOTE: state_nxt is given a default before the case. This ensures that no
   // path leaves it unassigned, so no latch is inferred.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (cmd_valid_i)               state_nxt = BUS;
         BUS:     if (wbm_ack_i || timeout_hit)  state_nxt = RESP;
         RESP:    if (rsp_ready_i)               state_nxt = IDLE;
         default:                                state_nxt = IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM: outputs decoded from state only
   // -------------------------------------------------------------------------
   always_comb begin
      cmd_ready_o = 1'b0;
      wbm_cyc_o   = 1'b0;
      unique case (state)
         IDLE:    cmd_ready_o = 1'b1;
         BUS:     wbm_cyc_o   = 1'b1;
         default: ;
      endcase
      wbm_stb_o = wbm_cyc_o;
   end

   // -------------------------------------------------------------------------
   // Bus and response datapath
   // -------------------------------------------------------------------------
   // NOTE: all datapath flops sit under the one synchronous reset. The block
   // has no memory array, so nothing is left without a reset.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wbm_we_q    <= 1'b0;
         wbm_sel_q   <= '0;
         wbm_adr_q   <= '0;
         wbm_dat_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_dat_q   <= '0;
         txn_cnt_q   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (cmd_valid_i) begin
                  wbm_we_q  <= cmd_we_i;
                  wbm_sel_q <= cmd_sel_i;
                  wbm_adr_q <= cmd_adr_i;
                  wbm_dat_q <= cmd_dat_i;
               end
            end
            BUS: begin
               if (wbm_ack_i || timeout_hit) begin
                  // Clear the bus fields so the bus is quiet whenever no
                  // cycle is running.
                  wbm_we_q    <= 1'b0;
                  wbm_sel_q   <= '0;
                  wbm_adr_q   <= '0;
                  wbm_dat_q   <= '0;
                  rsp_valid_q <= 1'b1;
                  rsp_dat_q   <= (wbm_ack_i && !wbm_we_q) ? wbm_dat_i : 32'd0;
                  if (wbm_ack_i) txn_cnt_q <= txn_cnt_q + CNT_W'(1);
               end
            end
            RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_q <= 1'b0;
                  rsp_dat_q   <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign wbm_we_o    = wbm_we_q;
   assign wbm_sel_o   = wbm_sel_q;
   assign wbm_adr_o   = wbm_adr_q;
   assign wbm_dat_o   = wbm_dat_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_dat_o   = rsp_dat_q;
   assign txn_cnt_o   = txn_cnt_q;

endmodule
